// File: rtl/glyph_row_streamer.sv
// glyph_row_streamer
// Accepts one character per handshake, fetches its bitmap through an external
// font-lookup port and streams the glyph one pixel row per beat, with integer
// scaling, inverse video and underline.
//
// Ports
//   clk_i, reset_i        sole clock; synchronous active-high reset
//   in_valid_i/in_ready_o character request handshake
//   in_code_i             ASCII code (non-printables map to space)
//   in_scale_i            scale factor (0 -> 1, clamped to MAX_SCALE)
//   in_inverse_i          invert pixels inside the scaled width
//   in_underline_i        force the last source row to all ones
//   font_code_o           registered code driven to the font lookup
//   font_bits_i           bitmap for font_code_o, row 0 in MSBs
//   out_valid_o/out_ready_i row beat handshake
//   out_data_o            scaled row, left-aligned, unused LSBs zero
//   out_row_o             output row index within the glyph
//   out_last_o            final row of the glyph
module glyph_row_streamer #(
  parameter int unsigned GLYPH_W   = 8,
  parameter int unsigned GLYPH_H   = 16,
  parameter int unsigned MAX_SCALE = 2,
  localparam int unsigned SW = $clog2(MAX_SCALE + 1),
  localparam int unsigned OW = GLYPH_W * MAX_SCALE,
  localparam int unsigned RW = (GLYPH_H * MAX_SCALE > 1) ? $clog2(GLYPH_H * MAX_SCALE) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [6:0]                 in_code_i,
  input  logic [SW-1:0]              in_scale_i,
  input  logic                       in_inverse_i,
  input  logic                       in_underline_i,
  output logic [6:0]                 font_code_o,
  input  logic [GLYPH_W*GLYPH_H-1:0] font_bits_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OW-1:0]              out_data_o,
  output logic [RW-1:0]              out_row_o,
  output logic                       out_last_o
);

  localparam int unsigned HW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned BW = GLYPH_W * GLYPH_H;
  localparam logic [6:0]  SPACE = 7'h20;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic [6:0]      code_q;
  logic [SW-1:0]   scale_q;
  logic            inv_q;
  logic            ul_q;
  logic [BW-1:0]   bitmap_q;
  logic [HW-1:0]   src_q;
  logic [SW-1:0]   rep_q;
  logic [RW-1:0]   row_q;
  logic            out_valid_q;
  logic [OW-1:0]   out_data_q;
  logic [RW-1:0]   out_row_q;
  logic            out_last_q;

  logic [6:0]      code_d;
  logic [SW-1:0]   scale_d;
  logic [BW-1:0]   shifted;
  logic [GLYPH_W-1:0] src_px;
  logic [OW-1:0]   row_d;
  logic [OW-1:0]   mask;
  logic            last_d;

  // Request sanitising: printable ASCII only, scale forced into 1..MAX_SCALE.
  always_comb begin
    code_d = in_code_i;
    if (in_code_i < 7'd32 || in_code_i > 7'd126) code_d = SPACE;
    scale_d = in_scale_i;
    if (in_scale_i == '0) scale_d = SW'(1);
    else if (32'(in_scale_i) > MAX_SCALE) scale_d = SW'(MAX_SCALE);
  end

  // Current source row pixels, with underline override on the bottom row.
  always_comb begin
    shifted = bitmap_q << (32'(src_q) * GLYPH_W);
    src_px  = shifted[BW-1 -: GLYPH_W];
    if (ul_q && src_q == HW'(GLYPH_H - 1)) src_px = '1;
  end

  // Horizontal replication; mask marks the scaled width so inversion never
  // touches the zero padding below it.
  always_comb begin
    row_d = '0;
    mask  = '0;
    for (int unsigned k = 1; k <= MAX_SCALE; k++) begin
      if (scale_q == SW'(k)) begin
        for (int unsigned i = 0; i < GLYPH_W; i++) begin
          for (int unsigned j = 0; j < k; j++) begin
            row_d[OW-1-i*k-j] = src_px[GLYPH_W-1-i];
            mask[OW-1-i*k-j]  = 1'b1;
          end
        end
      end
    end
    if (inv_q) row_d = row_d ^ mask;
    last_d = (src_q == HW'(GLYPH_H - 1)) && (rep_q == scale_q - SW'(1));
  end

  // Control FSM and registered outputs. The output register is refilled
  // whenever it is empty or its beat is being taken, giving one row per cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      code_q      <= SPACE;
      scale_q     <= SW'(1);
      inv_q       <= 1'b0;
      ul_q        <= 1'b0;
      bitmap_q    <= '0;
      src_q       <= '0;
      rep_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            code_q     <= code_d;
            scale_q    <= scale_d;
            inv_q      <= in_inverse_i;
            ul_q       <= in_underline_i;
            in_ready_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          bitmap_q <= font_bits_i;
          src_q    <= '0;
          rep_q    <= '0;
          row_q    <= '0;
          state_q  <= STREAM;
        end
        STREAM: begin
          if (out_valid_q && out_last_q) begin
            if (out_ready_i) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              out_row_q   <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end
          end else if (!out_valid_q || out_ready_i) begin
            out_valid_q <= 1'b1;
            out_data_q  <= row_d;
            out_row_q   <= row_q;
            out_last_q  <= last_d;
            row_q       <= row_q + RW'(1);
            if (rep_q == scale_q - SW'(1)) begin
              rep_q <= '0;
              src_q <= src_q + HW'(1);
            end else begin
              rep_q <= rep_q + SW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign font_code_o = code_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_row_o   = out_row_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_glyph_row_streamer.sv
// Scoreboard bench for glyph_row_streamer at default parameters (8/16/2).
module tb_glyph_row_streamer;
  localparam int unsigned GW = 8;
  localparam int unsigned GH = 16;
  localparam int unsigned MS = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned OW = 16;
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [RW-1:0] r;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_code = 7'h00;
  logic [SW-1:0] in_scale = '0;
  logic          in_inverse = 1'b0;
  logic          in_underline = 1'b0;
  logic [6:0]    font_code;
  logic [GW*GH-1:0] font_bits;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats = 0;
  int first_cyc = 0;
  int acc_cyc = 0;
  bit first_seen = 1'b0;
  bit stall_en = 1'b0;
  bit prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t exp_q[$];
  logic [OW-1:0] got [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_row_streamer dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_code_i(in_code), .in_scale_i(in_scale),
    .in_inverse_i(in_inverse), .in_underline_i(in_underline),
    .font_code_o(font_code), .font_bits_i(font_bits),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_row_o(out_row), .out_last_o(out_last)
  );

  // Font model: 'A' shape, blank space, a code-dependent pattern otherwise.
  function automatic logic [7:0] font_row(input logic [6:0] c, input int r);
    if (c == 7'h41) begin
      case (r)
        1:       return 8'h18;
        2:       return 8'h3C;
        5:       return 8'h7E;
        3, 4, 6, 7, 8: return 8'h66;
        default: return 8'h00;
      endcase
    end
    if (c == 7'h20) return 8'h00;
    return {c, 1'b1} ^ 8'(r);
  endfunction

  always_comb begin
    font_bits = '0;
    for (int r = 0; r < GH; r++)
      font_bits = {font_bits[GW*GH-GW-1:0], font_row(font_code, r)};
  end

  function automatic logic [OW-1:0] exp_data(input logic [6:0] c, input int s,
                                             input bit inv, input bit ul, input int r);
    logic [7:0]    px;
    logic [OW-1:0] d;
    int src;
    src = r / s;
    px = (ul && src == GH - 1) ? 8'hFF : font_row(c, src);
    d = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < s; j++)
        d[15 - i*s - j] = px[7 - i];
    if (inv) d = d ^ (16'hFFFF << (16 - 8*s));
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'(1));
        chk("stall_hold", 32'({out_data, out_row, out_last}), 32'(prev_beat));
      end
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(1), 32'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.d));
          chk("beat_row", 32'(out_row), 32'(e.r));
          chk("beat_last", 32'(out_last), 32'(e.l));
        end
        if (beats < 64) got[beats] = out_data;
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_row, out_last};
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_row", 32'(out_row), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_font_code", 32'(font_code), 32'(7'h20));
  endtask

  // Issues one request, pushes its expected beats and waits for completion
  // (or, when abort_at >= 0, resets the DUT after that many beats).
  task automatic send(input logic [6:0] c, input logic [SW-1:0] sc, input bit inv,
                      input bit ul, input bit pulse, input int abort_at);
    int es, n, guard;
    logic [6:0] ec;
    logic rdy;
    es = (sc == 0) ? 1 : ((int'(sc) > int'(MS)) ? int'(MS) : int'(sc));
    ec = (c < 7'd32 || c > 7'd126) ? 7'h20 : c;
    n  = GH * es;
    beats = 0;
    first_seen = 1'b0;
    for (int r = 0; r < n; r++)
      exp_q.push_back({exp_data(ec, es, inv, ul, r), RW'(r), r == n - 1});
    in_code = c; in_scale = sc; in_inverse = inv; in_underline = ul;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) chk("accept_timeout", 32'(0), 32'(1));
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_code = 7'h7F; in_scale = '0; in_inverse = ~inv; in_underline = ~ul;
    if (pulse) begin
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; in_code = 7'h42;
        chk("busy_in_ready", 32'(in_ready), 32'(0));
      end
      in_valid = 1'b0;
    end
    guard = 0;
    while (beats < ((abort_at >= 0) ? abort_at : n) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk("stream_timeout", 32'(beats), 32'(n));
    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs();
      reset = 1'b0;
      exp_q.delete();
    end else begin
      chk("beat_count", 32'(beats), 32'(n));
      chk("first_latency", 32'(first_cyc - acc_cyc), 32'(2));
      chk("in_ready_after", 32'(in_ready), 32'(1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();

    send(7'h41, 2'd1, 1'b0, 1'b0, 1'b0, -1);
    chk("A_s1_beat0", 32'(got[0]), 32'h0000);
    chk("A_s1_beat1", 32'(got[1]), 32'h1800);

    send(7'h41, 2'd2, 1'b0, 1'b0, 1'b0, -1);
    chk("A_s2_beat2", 32'(got[2]), 32'h03C0);
    chk("A_s2_beat3", 32'(got[3]), 32'h03C0);

    send(7'h41, 2'd0, 1'b0, 1'b0, 1'b0, -1);
    chk("A_s0_beats", 32'(beats), 32'd16);
    send(7'h41, 2'd3, 1'b0, 1'b0, 1'b0, -1);
    chk("A_s3_beats", 32'(beats), 32'd32);

    send(7'h41, 2'd1, 1'b1, 1'b0, 1'b0, -1);
    chk("A_inv_s1_beat0", 32'(got[0]), 32'hFF00);
    chk("A_inv_s1_beat1", 32'(got[1]), 32'hE700);
    send(7'h41, 2'd2, 1'b1, 1'b0, 1'b0, -1);
    chk("A_inv_s2_beat0", 32'(got[0]), 32'hFFFF);

    send(7'h20, 2'd2, 1'b0, 1'b1, 1'b0, -1);
    chk("sp_ul_beat0", 32'(got[0]), 32'h0000);
    chk("sp_ul_beat29", 32'(got[29]), 32'h0000);
    chk("sp_ul_beat30", 32'(got[30]), 32'hFFFF);
    chk("sp_ul_beat31", 32'(got[31]), 32'hFFFF);

    send(7'h05, 2'd2, 1'b0, 1'b1, 1'b0, -1);
    chk("ctrl_font_code", 32'(font_code), 32'h20);
    chk("ctrl_ul_beat30", 32'(got[30]), 32'hFFFF);

    stall_en = 1'b1;
    send(7'h41, 2'd2, 1'b0, 1'b0, 1'b1, -1);
    stall_en = 1'b0;
    chk("stall_beat2", 32'(got[2]), 32'h03C0);

    send(7'h41, 2'd1, 1'b0, 1'b0, 1'b0, 5);
    send(7'h41, 2'd1, 1'b0, 1'b0, 1'b0, -1);
    chk("post_rst_beat0", 32'(got[0]), 32'h0000);
    chk("post_rst_beat1", 32'(got[1]), 32'h1800);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
